// File: rtl/camera_seq_multirow.sv
// Frame sequencer: erase release, timed exposure, then NUM_ROWS ADC row reads with a 1-cycle gap.
// Outputs registered (one cycle after the deciding edge); init/exp_inc/exp_dec are ignored while busy.
module camera_seq_multirow #(
   parameter int NUM_ROWS    = 2,
   parameter int ADC_CYCLES  = 5,
   parameter int EXP_MIN     = 2,
   parameter int EXP_MAX     = 30,
   parameter int EXP_DEFAULT = 15,
   parameter int EXP_W       = $clog2(EXP_MAX + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   input  logic                exp_inc,
   input  logic                exp_dec,
   output logic [NUM_ROWS-1:0] nre,
   output logic                adc,
   output logic                expose,
   output logic                erase,
   output logic                busy,
   output logic                frame_done,
   output logic [EXP_W-1:0]    exp_time
);

   localparam int CNT_MAX = (EXP_MAX > ADC_CYCLES) ? EXP_MAX : ADC_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXPOSE, S_READ, S_GAP} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [ROW_W-1:0]      row, row_nxt;
   logic [EXP_W-1:0]      exp_snap, exp_snap_nxt, exp_time_nxt;
   logic                  frame_done_nxt;
   logic [NUM_ROWS-1:0]   nre_nxt;

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      row_nxt        = row;
      exp_snap_nxt   = exp_snap;
      exp_time_nxt   = exp_time;
      frame_done_nxt = 1'b0;
      nre_nxt        = '1;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            row_nxt = '0;
            // init outranks the exposure buttons; inc outranks dec
            if (init) begin
               state_nxt    = S_EXPOSE;
               exp_snap_nxt = exp_time;
            end else if (exp_inc) begin
               if (exp_time < EXP_W'(EXP_MAX))
                  exp_time_nxt = exp_time + EXP_W'(1);
            end else if (exp_dec) begin
               if (exp_time > EXP_W'(EXP_MIN))
                  exp_time_nxt = exp_time - EXP_W'(1);
            end
         end
         S_EXPOSE: begin
            if (cnt == CNT_W'(exp_snap) - CNT_W'(1)) begin
               state_nxt = S_READ;
               cnt_nxt   = '0;
               row_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_READ: begin
            if (cnt == CNT_W'(ADC_CYCLES - 1)) begin
               state_nxt = S_GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (row == ROW_W'(NUM_ROWS - 1)) begin
               state_nxt      = S_IDLE;
               frame_done_nxt = 1'b1;
            end else begin
               state_nxt = S_READ;
               row_nxt   = row + ROW_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // one-hot-low row enable decoded from the state being entered
      for (int r = 0; r < NUM_ROWS; r++)
         nre_nxt[r] = !(state_nxt == S_READ && row_nxt == ROW_W'(r));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         row        <= '0;
         exp_snap   <= EXP_W'(EXP_DEFAULT);
         exp_time   <= EXP_W'(EXP_DEFAULT);
         nre        <= '1;
         adc        <= 1'b0;
         expose     <= 1'b0;
         erase      <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         row        <= row_nxt;
         exp_snap   <= exp_snap_nxt;
         exp_time   <= exp_time_nxt;
         nre        <= nre_nxt;
         adc        <= (state_nxt == S_READ);
         expose     <= (state_nxt == S_EXPOSE);
         erase      <= (state_nxt == S_IDLE);
         busy       <= (state_nxt != S_IDLE);
         frame_done <= frame_done_nxt;
      end
   end

endmodule

// File: tb/tb_camera_seq_multirow.sv
// Bench for camera_seq_multirow: default-parameter instance plus a 4-row, 1-cycle-ADC instance.
module tb_camera_seq_multirow;

   logic       clk = 1'b0;
   logic       reset;
   logic       init0, inc0, dec0, init1, inc1, dec1;
   logic [1:0] nre0;
   logic [3:0] nre1;
   logic       adc0, expose0, erase0, busy0, fd0;
   logic       adc1, expose1, erase1, busy1, fd1;
   logic [4:0] exp_time0, exp_time1;

   int total = 0;
   int bad   = 0;
   logic [8:0] sb[$];

   typedef struct {
      bit inc;
      bit dec;
      int cycles;
      int exp;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   camera_seq_multirow dut (
      .clk(clk), .reset(reset), .init(init0), .exp_inc(inc0), .exp_dec(dec0),
      .nre(nre0), .adc(adc0), .expose(expose0), .erase(erase0), .busy(busy0),
      .frame_done(fd0), .exp_time(exp_time0));

   camera_seq_multirow #(.NUM_ROWS(4), .ADC_CYCLES(1), .EXP_DEFAULT(2)) dut4 (
      .clk(clk), .reset(reset), .init(init1), .exp_inc(inc1), .exp_dec(dec1),
      .nre(nre1), .adc(adc1), .expose(expose1), .erase(erase1), .busy(busy1),
      .frame_done(fd1), .exp_time(exp_time1));

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which, input bit i, input bit u, input bit d);
      if (which == 0) begin
         init0 = i; inc0 = u; dec0 = d;
      end else begin
         init1 = i; inc1 = u; dec1 = d;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] obs(input int which);
      if (which == 0)
         return {2'b11, nre0, adc0, expose0, erase0, busy0, fd0};
      return {nre1, adc1, expose1, erase1, busy1, fd1};
   endfunction

   function automatic int etime(input int which);
      return (which == 0) ? int'(exp_time0) : int'(exp_time1);
   endfunction

   // Expected {nre[3:0], adc, expose, erase, busy, frame_done} k cycles after the init edge
   function automatic logic [8:0] expect_at(input int k, input int e, input int a, input int n);
      logic [3:0] nre_e = 4'hF;
      logic adc_e = 1'b0, ex_e = 1'b0, er_e = 1'b0, bz_e = 1'b0, fd_e = 1'b0;
      int last = e + n * (a + 1) + 1;
      if (k >= 1 && k <= e) begin
         ex_e = 1'b1; bz_e = 1'b1;
      end else if (k > e && k < last) begin
         int j = k - e - 1;
         bz_e = 1'b1;
         if (j % (a + 1) < a) begin
            adc_e = 1'b1;
            nre_e[j / (a + 1)] = 1'b0;
         end
      end else if (k == last) begin
         er_e = 1'b1; fd_e = 1'b1;
      end else begin
         er_e = 1'b1;
      end
      return {nre_e, adc_e, ex_e, er_e, bz_e, fd_e};
   endfunction

   // Starts a frame, checks stop cycles of it (0 = whole frame, ending in the frame_done cycle)
   task automatic run_frame(input string tag, input int which, input int e, input int a,
                            input int n, input bit poke, input bit hold_init,
                            input bit inc_start, input int stop, input int exp_t);
      int last;
      int lim;
      logic [8:0] want;
      last = e + n * (a + 1) + 1;
      lim  = (stop == 0) ? last : stop;
      drive(which, 1'b1, inc_start, 1'b0);
      for (int k = 1; k <= last; k++) sb.push_back(expect_at(k, e, a, n));
      step();
      drive(which, hold_init, 1'b0, 1'b0);
      for (int k = 1; k <= lim; k++) begin
         if (sb.size() == 0) begin
            chk($sformatf("%s c%0d scoreboard empty", tag, k), 1, 0);
            want = '0;
         end else begin
            want = sb.pop_front();
         end
         chk($sformatf("%s c%0d outputs", tag, k), int'(obs(which)), int'(want));
         chk($sformatf("%s c%0d exp_time", tag, k), etime(which), exp_t);
         if (poke) begin
            case (k)
               5:  drive(which, 1'b0, 1'b1, 1'b0);
               10: drive(which, 1'b0, 1'b0, 1'b1);
               18: drive(which, 1'b1, 1'b0, 1'b0);
               22: drive(which, 1'b0, 1'b1, 1'b1);
               6, 12, 19, 23: drive(which, 1'b0, 1'b0, 1'b0);
               default: ;
            endcase
         end
         if (k < lim) step();
      end
      sb.delete();
   endtask

   initial begin
      int model;
      vecs[0] = '{1'b1, 1'b0, 20, 30};
      vecs[1] = '{1'b0, 1'b1, 40, 2};
      vecs[2] = '{1'b1, 1'b0, 1, 3};
      vecs[3] = '{1'b1, 1'b1, 1, 4};
      vecs[4] = '{1'b1, 1'b1, 30, 30};
      vecs[5] = '{1'b0, 1'b1, 1, 29};
      vecs[6] = '{1'b0, 1'b0, 3, 29};
      vecs[7] = '{1'b0, 1'b1, 14, 15};

      reset = 1'b1;
      drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      step();
      step();
      chk("reset outputs", int'(obs(0)), int'(expect_at(0, 15, 5, 2)));
      chk("reset exp_time", etime(0), 15);
      chk("reset outputs 4row", int'(obs(1)), int'(expect_at(0, 2, 1, 4)));
      chk("reset exp_time 4row", etime(1), 2);
      reset = 1'b0;
      step();

      // single frame with default timing
      run_frame("t1", 0, 15, 5, 2, 1'b0, 1'b0, 1'b0, 0, 15);
      step();
      chk("t1 after frame", int'(obs(0)), int'(expect_at(0, 15, 5, 2)));

      // exposure adjust: per-cycle saturating model plus table endpoints
      model = 15;
      foreach (vecs[v]) begin
         drive(0, 1'b0, vecs[v].inc, vecs[v].dec);
         for (int c = 0; c < vecs[v].cycles; c++) begin
            step();
            if (vecs[v].inc) model = (model < 30) ? model + 1 : model;
            else if (vecs[v].dec) model = (model > 2) ? model - 1 : model;
            chk($sformatf("adj v%0d c%0d", v, c), etime(0), model);
         end
         chk($sformatf("adj v%0d end", v), etime(0), vecs[v].exp);
      end
      drive(0, 0, 0, 0);
      step();

      // buttons and init poked mid-frame must not disturb anything
      run_frame("t3", 0, 15, 5, 2, 1'b1, 1'b0, 1'b0, 0, 15);
      step();

      // reset during row 0 read of a 16-cycle exposure
      drive(0, 1'b0, 1'b1, 1'b0);
      step();
      drive(0, 0, 0, 0);
      chk("t4 pre exp_time", etime(0), 16);
      run_frame("t4", 0, 16, 5, 2, 1'b0, 1'b0, 1'b0, 18, 16);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t4 reset outputs", int'(obs(0)), int'(expect_at(0, 15, 5, 2)));
      chk("t4 reset exp_time", etime(0), 15);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("t4 post c%0d", c), int'(obs(0)), int'(expect_at(0, 15, 5, 2)));
      end

      // four rows, one ADC cycle, exposure 2
      run_frame("t5", 1, 2, 1, 4, 1'b0, 1'b0, 1'b0, 0, 2);
      step();
      chk("t5 after frame", int'(obs(1)), int'(expect_at(0, 2, 1, 4)));

      // init with exp_inc, init held -> back-to-back frames
      run_frame("t6a", 0, 15, 5, 2, 1'b0, 1'b1, 1'b1, 0, 15);
      run_frame("t6b", 0, 15, 5, 2, 1'b0, 1'b0, 1'b0, 0, 15);
      step();
      chk("t6 after frames", int'(obs(0)), int'(expect_at(0, 15, 5, 2)));
      chk("t6 exp_time", etime(0), 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
